pifo_bypass_dispatcher: RTL and testbench

Sits directly downstream of the root-PIFO bypass checker in the root-only PIFO scheduler. Accepts each root descriptor and drives the checker's valid strobe. Waits for the registered bypass decision, then either:
- pushes the descriptor into a small bypass FIFO feeding egress, or
- issues it to the PIFO calendar insert port.

Also drops invalid descriptors, falls back to PIFO insert when the bypass FIFO is full, and keeps saturating event counters.

---
 rtl/pifo_root_pkg.sv | 24 ++
 rtl/pifo_bypass_fifo.sv | 54 +++++
 rtl/pifo_bypass_dispatcher.sv | 118 +++++++++++
 tb/tb_pifo_bypass_dispatcher.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pifo_root_pkg.sv
// rtl/pifo_root_pkg.sv - shared root-PIFO descriptor layout and dispatcher encodings
//
// Purpose: descriptor field positions for the root-only PIFO scheduler,
//          dispatcher state encoding and route encoding.
// Ports:   none (package).
package pifo_root_pkg;

   localparam int PIFO_ROOT_WIDTH          = 32;
   localparam int ROOT_PIFO_INFO_VALID_POS = 31;
   localparam int ROOT_PIFO_RANK_START     = 0;
   localparam int ROOT_PIFO_RANK_END       = 15;

   typedef enum logic [1:0] {
      DISP_IDLE     = 2'd0,
      DISP_WAIT_DEC = 2'd1,
      DISP_DISPATCH = 2'd2
   } disp_state_t;

   typedef enum logic {
      ROUTE_BYPASS = 1'b0,
      ROUTE_INSERT = 1'b1
   } route_t;

endpackage

// File: rtl/pifo_bypass_fifo.sv
// rtl/pifo_bypass_fifo.sv - parameterised first-word fall-through synchronous FIFO
//
// Purpose: small FWFT FIFO; head word is visible on rd_data whenever !empty.
// Ports:   clk, rstn (sync active-low)
//          wr_en, wr_data   - write side
//          rd_en, rd_data   - read side (rd_en pops the current head)
//          full, empty      - occupancy flags
module pifo_bypass_fifo #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  rd_en,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  full,
   output logic                  empty
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH:0]   wr_ptr;
   logic [ADDR_WIDTH:0]   rd_ptr;
   logic                  rd_ok;
   logic                  wr_ok;

   // Extra pointer MSB distinguishes full from empty when the low bits match.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                    (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);
   assign rd_data = mem[rd_ptr[ADDR_WIDTH-1:0]];
   assign rd_ok   = rd_en && !empty;
   // A write while full is only safe when the head leaves in the same cycle.
   assign wr_ok   = wr_en && (!full || rd_ok);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_ok) rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr[ADDR_WIDTH-1:0]] <= wr_data;
   end

endmodule

// File: rtl/pifo_bypass_dispatcher.sv
// rtl/pifo_bypass_dispatcher.sv - routes root descriptors to the bypass FIFO or PIFO insert
//
// Purpose: accepts root descriptors, strobes the bypass checker, waits for its
//          registered decision, then pushes into the bypass FIFO or issues a
//          PIFO calendar insert. Drops invalid descriptors, falls back to insert
//          when the FIFO is full, keeps saturating event counters.
// Ports:   clk, rstn (sync active-low)
//          s_axis_valid/ready/pifo_info       - upstream descriptor
//          chk_valid                          - checker input strobe
//          dec_valid, dec_bypass_en           - checker decision
//          m_axis_bypass_valid/ready/info     - bypass FIFO head to egress
//          m_axis_insert_valid/ready/info     - PIFO insert request
//          cnt_bypass/insert/fallback/drop    - saturating event counters
//          err_unexpected_dec                 - sticky, decision outside WAIT_DEC
module pifo_bypass_dispatcher #(
   parameter int PIFO_ROOT_WIDTH          = 32,
   parameter int ROOT_PIFO_INFO_VALID_POS = 31,
   parameter int BYPASS_FIFO_ADDR_WIDTH   = 2,
   parameter int CNT_WIDTH                = 16
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       s_axis_valid,
   output logic                       s_axis_ready,
   input  logic [PIFO_ROOT_WIDTH-1:0] s_axis_pifo_info,
   output logic                       chk_valid,
   input  logic                       dec_valid,
   input  logic                       dec_bypass_en,
   output logic                       m_axis_bypass_valid,
   input  logic                       m_axis_bypass_ready,
   output logic [PIFO_ROOT_WIDTH-1:0] m_axis_bypass_info,
   output logic                       m_axis_insert_valid,
   input  logic                       m_axis_insert_ready,
   output logic [PIFO_ROOT_WIDTH-1:0] m_axis_insert_info,
   output logic [CNT_WIDTH-1:0]       cnt_bypass,
   output logic [CNT_WIDTH-1:0]       cnt_insert,
   output logic [CNT_WIDTH-1:0]       cnt_fallback,
   output logic [CNT_WIDTH-1:0]       cnt_drop,
   output logic                       err_unexpected_dec
);

   import pifo_root_pkg::*;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
      return (&v) ? v : v + CNT_ONE;
   endfunction

   disp_state_t               state, state_nxt;
   route_t                    route;
   logic [PIFO_ROOT_WIDTH-1:0] hold;
   logic acc, info_vld, dec_take, fifo_wr, fifo_rd, fifo_full, fifo_empty;
   logic fallback_evt, insert_evt, drop_evt;

   assign s_axis_ready        = (state == DISP_IDLE);
   assign acc                 = s_axis_valid & s_axis_ready;
   assign info_vld            = s_axis_pifo_info[ROOT_PIFO_INFO_VALID_POS];
   assign chk_valid           = acc & info_vld;
   assign drop_evt            = acc & ~info_vld;
   assign dec_take            = (state == DISP_WAIT_DEC) & dec_valid;
   assign fallback_evt        = dec_take & dec_bypass_en & fifo_full;
   assign fifo_wr             = (state == DISP_DISPATCH) && (route == ROUTE_BYPASS);
   assign m_axis_insert_valid = (state == DISP_DISPATCH) && (route == ROUTE_INSERT);
   assign m_axis_insert_info  = hold;
   assign insert_evt          = m_axis_insert_valid & m_axis_insert_ready;
   assign m_axis_bypass_valid = ~fifo_empty;
   assign fifo_rd             = m_axis_bypass_valid & m_axis_bypass_ready;

   always_comb begin
      state_nxt = state;
      case (state)
         DISP_IDLE:     if (chk_valid) state_nxt = DISP_WAIT_DEC;
         DISP_WAIT_DEC: if (dec_valid) state_nxt = DISP_DISPATCH;
         DISP_DISPATCH: if (route == ROUTE_BYPASS || m_axis_insert_ready) state_nxt = DISP_IDLE;
         default:       state_nxt = DISP_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state              <= DISP_IDLE;
         route              <= ROUTE_BYPASS;
         hold               <= '0;
         cnt_bypass         <= '0;
         cnt_insert         <= '0;
         cnt_fallback       <= '0;
         cnt_drop           <= '0;
         err_unexpected_dec <= 1'b0;
      end else begin
         state <= state_nxt;
         if (chk_valid) hold <= s_axis_pifo_info;
         // FIFO fullness is sampled with the decision; only reads can happen
         // before the DISPATCH write, so a BYPASS route always finds space.
         if (dec_take) route <= (dec_bypass_en && !fifo_full) ? ROUTE_BYPASS : ROUTE_INSERT;
         if (fifo_wr)      cnt_bypass   <= sat_inc(cnt_bypass);
         if (insert_evt)   cnt_insert   <= sat_inc(cnt_insert);
         if (fallback_evt) cnt_fallback <= sat_inc(cnt_fallback);
         if (drop_evt)     cnt_drop     <= sat_inc(cnt_drop);
         if (dec_valid && state != DISP_WAIT_DEC) err_unexpected_dec <= 1'b1;
      end
   end

   pifo_bypass_fifo #(
      .DATA_WIDTH (PIFO_ROOT_WIDTH),
      .ADDR_WIDTH (BYPASS_FIFO_ADDR_WIDTH)
   ) u_bypass_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (fifo_wr),
      .wr_data (hold),
      .rd_en   (fifo_rd),
      .rd_data (m_axis_bypass_info),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

endmodule

// File: tb/tb_pifo_bypass_dispatcher.sv
// tb/tb_pifo_bypass_dispatcher.sv - self-checking bench for pifo_bypass_dispatcher
module tb_pifo_bypass_dispatcher;

   localparam int K_DROP = 0;
   localparam int K_BYP  = 1;
   localparam int K_INS  = 2;

   logic        clk = 1'b0;
   logic        rstn;
   logic        s_valid, s_ready, chk_valid;
   logic [31:0] info_in;
   logic        dec_valid, dec_byp;
   logic        byp_valid, egr_rdy;
   logic [31:0] byp_info;
   logic        ins_valid, ins_ready;
   logic [31:0] ins_info;
   logic [15:0] c_byp, c_ins, c_fb, c_drop;
   logic        err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   pifo_bypass_dispatcher dut (
      .clk                 (clk),
      .rstn                (rstn),
      .s_axis_valid        (s_valid),
      .s_axis_ready        (s_ready),
      .s_axis_pifo_info    (info_in),
      .chk_valid           (chk_valid),
      .dec_valid           (dec_valid),
      .dec_bypass_en       (dec_byp),
      .m_axis_bypass_valid (byp_valid),
      .m_axis_bypass_ready (egr_rdy),
      .m_axis_bypass_info  (byp_info),
      .m_axis_insert_valid (ins_valid),
      .m_axis_insert_ready (ins_ready),
      .m_axis_insert_info  (ins_info),
      .cnt_bypass          (c_byp),
      .cnt_insert          (c_ins),
      .cnt_fallback        (c_fb),
      .cnt_drop            (c_drop),
      .err_unexpected_dec  (err)
   );

   typedef struct {
      logic [31:0] info;
      logic        byp;
      int          stall;
      logic        exp_chk;
      int          kind;
   } vec_t;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] sat(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rstn = 1'b0; s_valid = 1'b0; info_in = '0; dec_valid = 1'b0; dec_byp = 1'b0;
      ins_ready = 1'b0; egr_rdy = 1'b0;
      tick();
      tick();
      rstn = 1'b1;
   endtask

   task automatic chk_counters(input string nm, input logic [15:0] b, input logic [15:0] i,
                               input logic [15:0] f, input logic [15:0] d);
      chk({nm, "_cnt_bypass"},   64'(c_byp),  64'(b));
      chk({nm, "_cnt_insert"},   64'(c_ins),  64'(i));
      chk({nm, "_cnt_fallback"}, 64'(c_fb),   64'(f));
      chk({nm, "_cnt_drop"},     64'(c_drop), 64'(d));
   endtask

   // One descriptor end to end, acting as upstream, checker and insert sink.
   // Starts and ends just after a rising edge with the DUT idle.
   task automatic send_one(input logic [31:0] info, input logic byp, input int stall,
                           input logic exp_chk, input int kind, input logic [31:0] exp_head);
      s_valid = 1'b1; info_in = info;
      @(negedge clk);
      chk("acc_ready", 64'(s_ready), 64'd1);
      chk("chk_valid", 64'(chk_valid), 64'(exp_chk));
      tick();
      s_valid = 1'b0;
      if (kind == K_DROP) begin
         @(negedge clk);
         chk("drop_ready", 64'(s_ready), 64'd1);
         chk("drop_no_insert", 64'(ins_valid), 64'd0);
         tick();
         return;
      end
      dec_valid = 1'b1; dec_byp = byp;
      @(negedge clk);
      chk("wait_ready_low", 64'(s_ready), 64'd0);
      tick();
      dec_valid = 1'b0; dec_byp = 1'b0;
      if (kind == K_BYP) begin
         @(negedge clk);
         chk("byp_no_insert", 64'(ins_valid), 64'd0);
         tick();
         @(negedge clk);
         chk("byp_ready_back", 64'(s_ready), 64'd1);
         chk("byp_valid", 64'(byp_valid), 64'd1);
         chk("byp_info", 64'(byp_info), 64'(exp_head));
         tick();
      end else begin
         for (int k = 0; k < stall; k++) begin
            ins_ready = 1'b0;
            @(negedge clk);
            chk("ins_hold_valid", 64'(ins_valid), 64'd1);
            chk("ins_hold_info", 64'(ins_info), 64'(info));
            tick();
         end
         ins_ready = 1'b1;
         @(negedge clk);
         chk("ins_valid", 64'(ins_valid), 64'd1);
         chk("ins_info", 64'(ins_info), 64'(info));
         tick();
         ins_ready = 1'b0;
         @(negedge clk);
         chk("ins_done_ready", 64'(s_ready), 64'd1);
         chk("ins_done_valid", 64'(ins_valid), 64'd0);
         tick();
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t        vecs[7];
      logic [31:0] fill[5];
      // random-phase model state
      logic        busy, cur_byp, route_byp, pop;
      int          age, stall_left, sz;
      logic [31:0] cur_info;
      logic [31:0] exp_q[$];
      logic [15:0] m_byp, m_ins, m_fb, m_drop;

      vecs[0] = '{32'h8000_5000, 1'b1, 0, 1'b1, K_BYP};
      vecs[1] = '{32'h8000_7000, 1'b0, 4, 1'b1, K_INS};
      vecs[2] = '{32'h0000_1234, 1'b1, 0, 1'b0, K_DROP};
      vecs[3] = '{32'hFFFF_FFFF, 1'b0, 0, 1'b1, K_INS};
      vecs[4] = '{32'h7FFF_FFFF, 1'b0, 0, 1'b0, K_DROP};
      vecs[5] = '{32'h8000_0001, 1'b1, 0, 1'b1, K_BYP};
      vecs[6] = '{32'h8123_4567, 1'b0, 1, 1'b1, K_INS};

      // reset values
      do_reset();
      @(negedge clk);
      chk("rst_ready", 64'(s_ready), 64'd1);
      chk("rst_byp_valid", 64'(byp_valid), 64'd0);
      chk("rst_ins_valid", 64'(ins_valid), 64'd0);
      chk("rst_ins_info", 64'(ins_info), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      chk_counters("rst", 16'd0, 16'd0, 16'd0, 16'd0);
      tick();

      // table-driven single descriptors, egress always ready
      egr_rdy = 1'b1;
      for (int v = 0; v < 7; v++)
         send_one(vecs[v].info, vecs[v].byp, vecs[v].stall, vecs[v].exp_chk, vecs[v].kind,
                  vecs[v].info);
      chk_counters("table", 16'd2, 16'd3, 16'd0, 16'd2);

      // FIFO fill with egress stalled: fifth bypass falls back to insert
      do_reset();
      for (int k = 0; k < 5; k++) begin
         fill[k] = 32'h8000_0100 + 32'(k);
         send_one(fill[k], 1'b1, 0, 1'b1, (k < 4) ? K_BYP : K_INS, fill[0]);
      end
      @(negedge clk);
      chk_counters("fill", 16'd4, 16'd1, 16'd1, 16'd0);
      tick();
      egr_rdy = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("drain_valid", 64'(byp_valid), 64'd1);
         chk("drain_info", 64'(byp_info), 64'(fill[k]));
         tick();
      end
      @(negedge clk);
      chk("drain_empty", 64'(byp_valid), 64'd0);
      tick();

      // unexpected decision while idle is sticky until reset
      dec_valid = 1'b1;
      tick();
      dec_valid = 1'b0;
      @(negedge clk);
      chk("err_set", 64'(err), 64'd1);
      repeat (3) tick();
      @(negedge clk);
      chk("err_sticky", 64'(err), 64'd1);
      rstn = 1'b0;
      tick();
      @(negedge clk);
      chk("err_cleared", 64'(err), 64'd0);
      rstn = 1'b1;
      tick();

      // randomized traffic against a transaction-level model
      do_reset();
      busy = 1'b0; age = 0; stall_left = 0; cur_byp = 1'b0; route_byp = 1'b0; cur_info = '0;
      m_byp = '0; m_ins = '0; m_fb = '0; m_drop = '0;
      exp_q.delete();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         egr_rdy   = ($urandom_range(0, 7) < ((cyc < 1500) ? 1 : 6));
         s_valid   = 1'b0; dec_valid = 1'b0; dec_byp = 1'b0; ins_ready = 1'b0;
         info_in   = $urandom;
         info_in[31] = ($urandom_range(0, 3) != 0);
         if (!busy) s_valid = ($urandom_range(0, 3) != 0);
         else if (age == 1) begin dec_valid = 1'b1; dec_byp = cur_byp; end
         else if (!route_byp) ins_ready = (stall_left == 0);
         @(negedge clk);
         chk("rnd_ready", 64'(s_ready), 64'(!busy));
         chk("rnd_chk_valid", 64'(chk_valid), 64'(!busy && s_valid && info_in[31]));
         chk("rnd_ins_valid", 64'(ins_valid), 64'(busy && age >= 2 && !route_byp));
         if (busy && age >= 2 && !route_byp) chk("rnd_ins_info", 64'(ins_info), 64'(cur_info));
         chk("rnd_byp_valid", 64'(byp_valid), 64'(exp_q.size() != 0));
         if (exp_q.size() != 0) chk("rnd_byp_info", 64'(byp_info), 64'(exp_q[0]));
         @(posedge clk);
         #1;
         sz  = exp_q.size();
         pop = (sz != 0) && egr_rdy;
         if (pop) void'(exp_q.pop_front());
         if (!busy) begin
            if (s_valid) begin
               if (info_in[31]) begin
                  busy = 1'b1; age = 1; cur_info = info_in;
                  cur_byp = ($urandom_range(0, 2) != 0);
                  stall_left = $urandom_range(0, 3);
               end else m_drop = sat(m_drop);
            end
         end else if (age == 1) begin
            route_byp = cur_byp && (sz < 4);
            if (cur_byp && !route_byp) m_fb = sat(m_fb);
            age = 2;
         end else if (route_byp) begin
            exp_q.push_back(cur_info); m_byp = sat(m_byp); busy = 1'b0;
         end else if (ins_ready) begin
            m_ins = sat(m_ins); busy = 1'b0;
         end else stall_left--;
      end
      s_valid = 1'b0; dec_valid = 1'b0; ins_ready = 1'b0;
      @(negedge clk);
      chk_counters("rnd", m_byp, m_ins, m_fb, m_drop);
      chk("rnd_err", 64'(err), 64'd0);
      tick();

      // drop counter saturation
      do_reset();
      s_valid = 1'b1; info_in = 32'h0000_1234;
      repeat (65535) @(posedge clk);
      #1;
      @(negedge clk);
      chk("drop_at_max", 64'(c_drop), 64'hFFFF);
      chk("drop_sat_ready", 64'(s_ready), 64'd1);
      tick();
      s_valid = 1'b0;
      @(negedge clk);
      chk("drop_saturated", 64'(c_drop), 64'hFFFF);
      tick();

      // reset while an insert is pending in DISPATCH and the FIFO holds data
      egr_rdy = 1'b0;
      send_one(32'h8000_AAAA, 1'b1, 0, 1'b1, K_BYP, 32'h8000_AAAA);
      s_valid = 1'b1; info_in = 32'h8000_9999;
      tick();
      s_valid = 1'b0; dec_valid = 1'b1; dec_byp = 1'b0;
      tick();
      dec_valid = 1'b0;
      @(negedge clk);
      chk("pre_rst_ins_valid", 64'(ins_valid), 64'd1);
      rstn = 1'b0;
      tick();
      @(negedge clk);
      chk("mid_rst_ready", 64'(s_ready), 64'd1);
      chk("mid_rst_byp_valid", 64'(byp_valid), 64'd0);
      chk("mid_rst_ins_valid", 64'(ins_valid), 64'd0);
      chk("mid_rst_ins_info", 64'(ins_info), 64'd0);
      chk("mid_rst_chk_valid", 64'(chk_valid), 64'd0);
      chk("mid_rst_err", 64'(err), 64'd0);
      chk_counters("mid_rst", 16'd0, 16'd0, 16'd0, 16'd0);
      rstn = 1'b1;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
